// File: rtl/vending_ctrl_param_if.sv
// vending_ctrl_param_if: coin, selection, restock and dispense/change signals of the vending controller
interface vending_ctrl_param_if #(
    parameter int NUM_PROD = 4,
    parameter int CREDIT_W = 8
);
    localparam int SEL_W = $clog2(NUM_PROD);
    logic                coin_valid;
    logic [2:0]          coin_val;
    logic                sel_valid;
    logic [SEL_W-1:0]    sel;
    logic                cancel;
    logic                restock_valid;
    logic [SEL_W-1:0]    restock_sel;
    logic                vend_valid;
    logic [SEL_W-1:0]    vend_prod;
    logic                change_valid;
    logic [CREDIT_W-1:0] change_amt;
    logic                coin_reject;
    logic                sel_err;
    logic [CREDIT_W-1:0] credit;
    logic                busy;
    modport master (
        output coin_valid, coin_val, sel_valid, sel, cancel, restock_valid, restock_sel,
        input  vend_valid, vend_prod, change_valid, change_amt, coin_reject, sel_err, credit, busy
    );
    modport slave (
        input  coin_valid, coin_val, sel_valid, sel, cancel, restock_valid, restock_sel,
        output vend_valid, vend_prod, change_valid, change_amt, coin_reject, sel_err, credit, busy
    );
endinterface

// File: rtl/vending_ctrl_param.sv
// vending_ctrl_param: coin credit, priced multi-product vend with stock tracking, change and refund
module vending_ctrl_param #(
    parameter int                           NUM_PROD   = 4,
    parameter int                           CREDIT_W   = 8,
    parameter logic [NUM_PROD*CREDIT_W-1:0] PRICES     = 32'h04030201,
    parameter int                           MAX_CREDIT = 20,
    parameter int                           STOCK_W    = 4,
    parameter int                           INIT_STOCK = 8
) (
    input logic               clk,
    input logic               rst,
    vending_ctrl_param_if.slave bus
);
    localparam int SEL_W = $clog2(NUM_PROD);
    typedef enum logic [1:0] {IDLE, CREDIT, DISPENSE, CHANGE} state_e;
    state_e              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d, change_amt_q, price;
    logic [CREDIT_W:0]   sum;
    logic [SEL_W-1:0]    prod_q, prod_d, sel_idx;
    logic [STOCK_W-1:0]  stock_q [NUM_PROD];
    logic                vend_valid_q, change_valid_q, busy_q;
    logic                coin_reject_q, coin_reject_d, sel_err_q, sel_err_d;
    logic                take, sel_ok, sel_good, coin_ok;
    assign sel_ok   = int'(bus.sel) < NUM_PROD;
    assign sel_idx  = sel_ok ? bus.sel : '0;
    assign price    = PRICES[sel_idx*CREDIT_W +: CREDIT_W];
    assign sel_good = sel_ok && stock_q[sel_idx] != '0 && credit_q >= price;
    // one extra bit so a coin can never wrap the credit before the ceiling check
    assign sum      = {1'b0, credit_q} + (CREDIT_W+1)'(bus.coin_val);
    assign coin_ok  = bus.coin_val inside {[3'd1:3'd5]} && sum <= (CREDIT_W+1)'(MAX_CREDIT);
    always_comb begin
        state_d       = state_q;
        credit_d      = credit_q;
        prod_d        = prod_q;
        take          = 1'b0;
        coin_reject_d = 1'b0;
        sel_err_d     = 1'b0;
        case (state_q)
            IDLE, CREDIT: begin
                if (bus.cancel) begin
                    coin_reject_d = bus.coin_valid;
                    state_d       = state_q == CREDIT ? CHANGE : IDLE;
                end else if (bus.sel_valid) begin
                    coin_reject_d = bus.coin_valid;
                    sel_err_d     = !sel_good;
                    if (sel_good) begin
                        credit_d = credit_q - price;
                        prod_d   = bus.sel;
                        take     = 1'b1;
                        state_d  = DISPENSE;
                    end
                end else if (bus.coin_valid) begin
                    coin_reject_d = !coin_ok;
                    if (coin_ok) begin
                        credit_d = sum[CREDIT_W-1:0];
                        state_d  = CREDIT;
                    end
                end
            end
            DISPENSE: begin
                coin_reject_d = bus.coin_valid;
                state_d       = credit_q != '0 ? CHANGE : IDLE;
            end
            default: begin
                coin_reject_d = bus.coin_valid;
                credit_d      = '0;
                state_d       = IDLE;
            end
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            credit_q       <= '0;
            prod_q         <= '0;
            vend_valid_q   <= 1'b0;
            change_valid_q <= 1'b0;
            change_amt_q   <= '0;
            coin_reject_q  <= 1'b0;
            sel_err_q      <= 1'b0;
            busy_q         <= 1'b0;
            for (int i = 0; i < NUM_PROD; i++) stock_q[i] <= STOCK_W'(INIT_STOCK);
        end else begin
            state_q        <= state_d;
            credit_q       <= credit_d;
            prod_q         <= prod_d;
            vend_valid_q   <= state_d == DISPENSE;
            change_valid_q <= state_d == CHANGE;
            change_amt_q   <= state_d == CHANGE ? credit_d : '0;
            coin_reject_q  <= coin_reject_d;
            sel_err_q      <= sel_err_d;
            busy_q         <= state_d == DISPENSE || state_d == CHANGE;
            // restock overrides a same-cycle dispense decrement of the same product
            for (int i = 0; i < NUM_PROD; i++)
                if (bus.restock_valid && int'(bus.restock_sel) == i) stock_q[i] <= STOCK_W'(INIT_STOCK);
                else if (take && int'(prod_d) == i) stock_q[i] <= stock_q[i] - 1'b1;
        end
    end
    assign bus.vend_valid   = vend_valid_q;
    assign bus.vend_prod    = prod_q;
    assign bus.change_valid = change_valid_q;
    assign bus.change_amt   = change_amt_q;
    assign bus.coin_reject  = coin_reject_q;
    assign bus.sel_err      = sel_err_q;
    assign bus.credit       = credit_q;
    assign bus.busy         = busy_q;
endmodule

// File: doc/vending_ctrl_param.md
# vending_ctrl_param

Parametrised vending-machine controller: accumulates coin credit, serves one of `NUM_PROD` products at per-product prices, tracks per-product stock, returns change, and supports cancel/refund and restock. All money is in units of 10 rs. It replaces fixed-product, fixed-price vending FSMs in the product-dispense datapath. It sits between the coin-acceptor front end and the dispenser/change-hopper drivers.

## Interface

Parameters:
- `NUM_PROD`, 4: number of products, 2..16. `SEL_W = $clog2(NUM_PROD)`.
- `CREDIT_W`, 8: width of credit, price and change values.
- `PRICES`, 32'h04030201: packed price list. Product i price is `PRICES[i*CREDIT_W +: CREDIT_W]`. Every price must be nonzero and ≤ `MAX_CREDIT`.
- `MAX_CREDIT`, 20: credit ceiling, must be < 2^CREDIT_W.
- `STOCK_W`, 4: width of each stock counter.
- `INIT_STOCK`, 8: stock loaded on reset and on restock, must be < 2^STOCK_W.

Ports:
- `clk` in 1: clock. All state changes on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `coin_valid` in 1: a coin is presented this cycle.
- `coin_val` in 3: coin value, 1..5. Values 0, 6 and 7 are invalid.
- `sel_valid` in 1: a product selection is presented this cycle.
- `sel` in `SEL_W`: selected product index.
- `cancel` in 1: refund request.
- `restock_valid` in 1: restock request.
- `restock_sel` in `SEL_W`: product to restock.
- `vend_valid` out 1: one-cycle dispense pulse.
- `vend_prod` out `SEL_W`: product being dispensed. Valid only while `vend_valid` is high.
- `change_valid` out 1: one-cycle change/refund pulse.
- `change_amt` out `CREDIT_W`: amount to return. Valid only while `change_valid` is high.
- `coin_reject` out 1: one-cycle pulse; the presented coin must be returned.
- `sel_err` out 1: one-cycle pulse; the selection was refused.
- `credit` out `CREDIT_W`: current credit.
- `busy` out 1: high in DISPENSE and CHANGE.

## Operation

- States: IDLE, CREDIT, DISPENSE, CHANGE. All outputs are registered.
- Reset:
  - State goes to IDLE.
  - `credit` = 0.
  - Every stock counter = `INIT_STOCK`.
  - All pulse outputs, `vend_prod`, `change_amt` and `busy` = 0.
  - Reset mid-operation discards credit; no change is issued.
- Input priority in IDLE and CREDIT: `cancel` > `sel_valid` > `coin_valid`.
  - A coin presented in the same cycle as `cancel` or `sel_valid` is rejected (`coin_reject`), whatever happens to the selection.
- Coin acceptance, in IDLE or CREDIT:
  - Accepted if `coin_val` is 1..5 and `credit + coin_val ≤ MAX_CREDIT`. Then `credit += coin_val` and the state goes to CREDIT.
  - Otherwise `coin_reject` pulses and `credit` is unchanged.
  - Coins presented in DISPENSE or CHANGE are always rejected.
- Selection, in IDLE or CREDIT:
  - Refused when `sel ≥ NUM_PROD`, `stock[sel] == 0`, or `credit < price[sel]`. A refusal pulses `sel_err`; credit and state are unchanged.
  - Otherwise: `credit -= price[sel]`, `stock[sel] -= 1`, latch the product index, go to DISPENSE.
- DISPENSE (exactly 1 cycle):
  - `vend_valid` = 1 and `vend_prod` = the latched index.
  - Next state is CHANGE if `credit > 0`, else IDLE.
- CHANGE (exactly 1 cycle):
  - `change_valid` = 1 and `change_amt` = `credit`.
  - Next cycle: `credit` = 0, state IDLE.
- Cancel:
  - In CREDIT, go to CHANGE (full refund).
  - In IDLE, no effect.
  - In DISPENSE or CHANGE, ignored.
- Restock is accepted in any state.
  - It loads `stock[restock_sel] = INIT_STOCK`.
  - An out-of-range `restock_sel` is ignored.
  - If it hits the same product as a dispense decrement in the same cycle, restock wins.
- One transaction equals one product. Extra credit is always returned; it is never carried over.
- Arithmetic: credit never exceeds `MAX_CREDIT` and never underflows (guaranteed by the checks above). Stock never underflows.

## Timing

- Coin sampled at edge k: `credit` is updated in cycle k+1, or `coin_reject` is high in cycle k+1.
- Selection sampled at edge k:
  - On success, `vend_valid` is high in cycle k+1 and `credit` already shows the remainder.
  - On refusal, `sel_err` is high in cycle k+1.
- Change (if any) is issued in cycle k+2 and `credit` reads 0 in cycle k+3.
- The earliest next accepted coin or selection is sampled at the edge ending the last busy cycle.
- Cancel sampled at edge k: `change_valid` is high in cycle k+1.
- `rst` high at edge k: all outputs read their reset values in cycle k+1. `rst` takes priority over every input.

## Test plan

- Reset, coin 2, coin 1 → `credit` = 3; sel 2 → `vend_valid` = 1 with `vend_prod` = 2 one cycle later, no `change_valid`, `credit` = 0, state IDLE.
- Coin 5, sel 0 → `vend_valid` then `change_valid` with `change_amt` = 4 on the next cycle; `busy` is high for 2 cycles.
- Coin 1, sel 3 → `sel_err`, `credit` stays 1; then cancel → `change_valid` with `change_amt` = 1; the bench also checks the coin-7 rejection and `sel = NUM_PROD` rejection paths.
- With `INIT_STOCK` = 2: buy product 1 twice (coin 2 each time) → two vends. Third attempt with credit 2 → `sel_err`, credit kept. Restock product 1, then sel 1 → vend succeeds.
- Credit 18, coin 3 → `coin_reject`, credit 18; coin 2 → credit 20. Coin 1 presented together with sel 1 → `coin_reject` plus vend, then `change_amt` = 18.
- Credit 4 with `rst` coincident with sel 3 → no `vend_valid`, no `change_valid`, `credit` = 0, every stock counter = `INIT_STOCK`.
